// File: rtl/oup_ulpi_link.sv
// ULPI link-side sequencer: PHY register write/read, RX CMD capture FIFO, NXT/DIR timeouts.
// Optional macro OUP_ULPI_EXTREG_EN enables extended-register access (0x40-0xFF) via EXTADDR.
module oup_ulpi_link #(
  parameter int RXCMD_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       ulpi_clk_i,
  input  logic       rst_i,
  input  logic [7:0] ins_instruction_i,
  input  logic       ins_exec_i,
  input  logic       ins_reset_i,
  output logic       ins_busy_o,
  output logic       ins_exec_done_o,
  output logic       ins_exec_aborted_o,
  input  logic [7:0] phyreg_addr_i,
  input  logic [7:0] phyreg_data_i,
  output logic [7:0] phyreg_data_o,
  output logic       phyreg_data_load_o,
  output logic [7:0] rx_cmd_byte_o,
  output logic       rx_cmd_valid_o,
  input  logic       rx_cmd_pop_i,
  output logic       rx_cmd_overflow_o,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe_o,
  input  logic       ulpi_dir_i,
  output logic       ulpi_stp_o,
  input  logic       ulpi_nxt_i
);
  localparam int AW = $clog2(RXCMD_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(RXCMD_DEPTH);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TXCMD   = 3'd1;
`ifdef OUP_ULPI_EXTREG_EN
  localparam logic [2:0] S_EXTADDR = 3'd2;
`endif
  localparam logic [2:0] S_WDATA   = 3'd3;
  localparam logic [2:0] S_STP     = 3'd4;
  localparam logic [2:0] S_RTURN   = 3'd5;
  localparam logic [2:0] S_RWAIT   = 3'd7;

  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic          r_dir_q;
  logic          r_write;
`ifdef OUP_ULPI_EXTREG_EN
  logic [7:0]    r_addr;
`else
  logic [5:0]    r_addr;
`endif
  logic [7:0]    r_wdata;
  logic          r_pre_abort;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_rdata;
  logic          r_rdata_load;

  logic [7:0]    r_fifo [RXCMD_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_srst, w_own, w_dir_rise, w_addr_phase, w_tx_state, w_capture;
  logic w_dir_abort, w_tmo_abort, w_tmo_hit, w_start, w_op_ok, w_addr_ok;
  logic w_push, w_push_ok, w_pop_ok, w_empty, w_full;
  logic [5:0] w_addr_field;
  logic [7:0] w_tx_byte;

  assign w_srst     = rst_i | ins_reset_i;
  assign w_own      = ~ulpi_dir_i & ~r_dir_q;
  assign w_dir_rise = ulpi_dir_i & ~r_dir_q;
  assign w_tmo_hit  = (r_tmo == TMO_MAX);
  assign w_capture  = (r_state == S_RTURN) & ulpi_dir_i & r_dir_q;

`ifdef OUP_ULPI_EXTREG_EN
  logic w_ext;
  assign w_ext        = |r_addr[7:6];
  assign w_addr_phase = (r_state == S_TXCMD) | (r_state == S_EXTADDR);
  assign w_addr_ok    = 1'b1;
  assign w_addr_field = w_ext ? 6'h2F : r_addr[5:0];
`else
  assign w_addr_phase = (r_state == S_TXCMD);
  assign w_addr_ok    = ~|phyreg_addr_i[7:6];
  assign w_addr_field = r_addr[5:0];
`endif

  assign w_tx_state  = w_addr_phase | (r_state == S_WDATA);
  assign w_dir_abort = w_tx_state & w_dir_rise;
  // Timeout counts every cycle spent waiting, regardless of who owns the bus.
  assign w_tmo_abort = w_tmo_hit & ((w_addr_phase & ~(ulpi_nxt_i & w_own))
                                  | ((r_state == S_RTURN) & ~w_capture)
                                  | ((r_state == S_RWAIT) & ulpi_dir_i));

  assign w_start = ins_exec_i & (r_state == S_IDLE) & ~r_pre_abort;
  assign w_op_ok = (ins_instruction_i == 8'h01) | (ins_instruction_i == 8'h02);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start & w_op_ok & w_addr_ok) w_state_next = S_TXCMD;
      S_TXCMD: begin
        if (w_dir_abort | w_tmo_abort) w_state_next = S_IDLE;
        else if (ulpi_nxt_i & w_own) begin
`ifdef OUP_ULPI_EXTREG_EN
          if (w_ext) w_state_next = S_EXTADDR; else
`endif
          w_state_next = r_write ? S_WDATA : S_RTURN;
        end
      end
`ifdef OUP_ULPI_EXTREG_EN
      S_EXTADDR: begin
        if (w_dir_abort | w_tmo_abort) w_state_next = S_IDLE;
        else if (ulpi_nxt_i & w_own) w_state_next = r_write ? S_WDATA : S_RTURN;
      end
`endif
      S_WDATA: begin
        if (w_dir_abort) w_state_next = S_IDLE;
        else if (ulpi_nxt_i & w_own) w_state_next = S_STP;
      end
      S_STP:   w_state_next = S_IDLE;
      S_RTURN: begin
        if (w_capture) w_state_next = S_RWAIT;
        else if (w_tmo_abort) w_state_next = S_IDLE;
      end
      S_RWAIT: if (~ulpi_dir_i | w_tmo_abort) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_byte = 8'h00;
    case (r_state)
      S_TXCMD:   w_tx_byte = {1'b1, ~r_write, w_addr_field};
`ifdef OUP_ULPI_EXTREG_EN
      S_EXTADDR: w_tx_byte = r_addr;
`endif
      S_WDATA:   w_tx_byte = r_wdata;
      default:   w_tx_byte = 8'h00;
    endcase
  end

  assign ulpi_data_oe_o     = w_own & (w_tx_state | (r_state == S_STP)) & ~w_tmo_abort;
  assign ulpi_data_o        = ulpi_data_oe_o ? w_tx_byte : 8'h00;
  assign ulpi_stp_o         = (r_state == S_STP);
  assign ins_busy_o         = (r_state != S_IDLE) | r_pre_abort;
  assign ins_exec_done_o    = (r_state == S_STP) | ((r_state == S_RWAIT) & ~ulpi_dir_i);
  assign ins_exec_aborted_o = r_pre_abort | w_dir_abort | w_tmo_abort;
  assign phyreg_data_o      = r_rdata;
  assign phyreg_data_load_o = r_rdata_load;

  always_ff @(posedge ulpi_clk_i) begin
    if (w_srst) begin
      r_state      <= S_IDLE;
      r_dir_q      <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 8'h00;
      r_pre_abort  <= 1'b0;
      r_tmo        <= '0;
      r_rdata      <= 8'h00;
      r_rdata_load <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_dir_q      <= ulpi_dir_i;
      r_pre_abort  <= w_start & ~(w_op_ok & w_addr_ok);
      r_rdata_load <= w_capture;
      if (w_start) begin
        r_write <= (ins_instruction_i == 8'h01);
        r_addr  <= phyreg_addr_i[$bits(r_addr)-1:0];
        r_wdata <= phyreg_data_i;
      end
      if (w_capture) r_rdata <= ulpi_data_i;
      // RTURN and RWAIT share one budget, so the count carries across that edge.
      if ((w_state_next != r_state) && !(r_state == S_RTURN && w_state_next == S_RWAIT))
        r_tmo <= '0;
      else if (!w_tmo_hit)
        r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FIFO_FULL);
  assign w_push    = ulpi_dir_i & r_dir_q & ~ulpi_nxt_i & ~w_capture;
  assign w_pop_ok  = rx_cmd_pop_i & ~w_empty;
  assign w_push_ok = w_push & (~w_full | w_pop_ok);

  assign rx_cmd_valid_o    = ~w_empty;
  assign rx_cmd_byte_o     = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign rx_cmd_overflow_o = r_overflow;

  always_ff @(posedge ulpi_clk_i) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= ulpi_data_i;
  end

  always_ff @(posedge ulpi_clk_i) begin
    if (w_srst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok & ~w_pop_ok)      r_count <= r_count + 1'b1;
      else if (~w_push_ok & w_pop_ok) r_count <= r_count - 1'b1;
      if (w_push & w_full & ~w_pop_ok) r_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_oup_ulpi_link.sv
// Directed bench for oup_ulpi_link (RXCMD_DEPTH=4, TIMEOUT_CYCLES=8); honours OUP_ULPI_EXTREG_EN.
module tb_oup_ulpi_link;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       exec = 1'b0;
  logic       ins_rst = 1'b0;
  logic       busy, done, aborted;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       rload;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_pop = 1'b0;
  logic       rx_ovf;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       oe;
  logic       dir = 1'b0;
  logic       stp;
  logic       nxt = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  oup_ulpi_link #(.RXCMD_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .ulpi_clk_i(clk), .rst_i(rst),
    .ins_instruction_i(instr), .ins_exec_i(exec), .ins_reset_i(ins_rst),
    .ins_busy_o(busy), .ins_exec_done_o(done), .ins_exec_aborted_o(aborted),
    .phyreg_addr_i(addr), .phyreg_data_i(wdata), .phyreg_data_o(rdata),
    .phyreg_data_load_o(rload),
    .rx_cmd_byte_o(rx_byte), .rx_cmd_valid_o(rx_valid), .rx_cmd_pop_i(rx_pop),
    .rx_cmd_overflow_o(rx_ovf),
    .ulpi_data_i(d_in), .ulpi_data_o(d_out), .ulpi_data_oe_o(oe),
    .ulpi_dir_i(dir), .ulpi_stp_o(stp), .ulpi_nxt_i(nxt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
    instr = op; addr = a; wdata = d; exec = 1'b1;
    cyc();
    exec = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (3) cyc();
    rst = 1'b0; #1;
    chk("rst_busy", busy, 0); chk("rst_oe", oe, 0); chk("rst_data", d_out, 8'h00);
    chk("rst_stp", stp, 0); chk("rst_valid", rx_valid, 0); chk("rst_ovf", rx_ovf, 0);
    chk("rst_done", done, 0); chk("rst_abort", aborted, 0); chk("rst_rdata", rdata, 0);
    $display("txn reset");

    // Write 0x0A <- 0x55, NXT on 2nd TXCMD cycle and 1st data cycle
    start(8'h01, 8'h0A, 8'h55); #1;
    chk("wr_tx1", d_out, 8'h8A); chk("wr_oe1", oe, 1); chk("wr_busy", busy, 1);
    cyc(); nxt = 1'b1; #1;
    chk("wr_tx2", d_out, 8'h8A);
    cyc(); #1;
    chk("wr_data", d_out, 8'h55); chk("wr_data_oe", oe, 1);
    cyc(); nxt = 1'b0; #1;
    chk("wr_stp", stp, 1); chk("wr_stp_data", d_out, 8'h00); chk("wr_done", done, 1);
    chk("wr_no_abort", aborted, 0);
    cyc(); #1;
    chk("wr_idle_stp", stp, 0); chk("wr_idle_done", done, 0); chk("wr_idle_busy", busy, 0);
    $display("txn write addr=0x0a data=0x55");

    // Read 0x16 returning 0x3C
    start(8'h02, 8'h16, 8'h00); nxt = 1'b1; #1;
    chk("rd_tx", d_out, 8'hD6);
    cyc(); nxt = 1'b0; #1;
    chk("rd_turn_oe", oe, 0); chk("rd_turn_data", d_out, 8'h00);
    cyc(); dir = 1'b1; d_in = 8'hAA; #1;
    chk("rd_dirup_abort", aborted, 0);
    cyc(); d_in = 8'h3C;
    cyc(); dir = 1'b0; d_in = 8'h00; #1;
    chk("rd_load", rload, 1); chk("rd_data", rdata, 8'h3C); chk("rd_done", done, 1);
    chk("rd_no_push", rx_valid, 0);
    cyc(); #1;
    chk("rd_load_end", rload, 0); chk("rd_done_end", done, 0); chk("rd_busy_end", busy, 0);
    $display("txn read addr=0x16 data=0x%02h", rdata);

    // Unsupported opcode
    start(8'h07, 8'h01, 8'h00); #1;
    chk("bad_op_abort", aborted, 1); chk("bad_op_oe", oe, 0);
    cyc(); #1;
    chk("bad_op_abort_end", aborted, 0); chk("bad_op_busy", busy, 0);
    $display("txn unsupported opcode 0x07");

    // DIR rises during WDATA, then RX CMD bytes 0x11, 0x22
    start(8'h01, 8'h05, 8'h77); nxt = 1'b1; #1;
    chk("da_tx", d_out, 8'h85);
    cyc(); nxt = 1'b0; #1;
    chk("da_data", d_out, 8'h77);
    cyc(); dir = 1'b1; #1;
    chk("da_abort", aborted, 1); chk("da_oe", oe, 0); chk("da_stp", stp, 0);
    chk("da_bus", d_out, 8'h00);
    cyc(); d_in = 8'h11; #1;
    chk("da_abort_end", aborted, 0); chk("da_stp_after", stp, 0); chk("da_busy", busy, 0);
    cyc(); d_in = 8'h22;
    cyc(); dir = 1'b0; d_in = 8'h00; #1;
    chk("rx_valid", rx_valid, 1); chk("rx_head0", rx_byte, 8'h11);
    rx_pop = 1'b1; cyc(); rx_pop = 1'b0; #1;
    chk("rx_head1", rx_byte, 8'h22);
    rx_pop = 1'b1; cyc(); rx_pop = 1'b0; #1;
    chk("rx_empty", rx_valid, 0);
    $display("txn write aborted by dir, rxcmd 0x11 0x22");

    // NXT never asserted: abort after 8 driven cycles
    start(8'h01, 8'h01, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("to_wait%0d", k), aborted, 0);
      chk($sformatf("to_oe%0d", k), oe, 1);
      cyc();
    end
    #1;
    chk("to_abort", aborted, 1); chk("to_oe_drop", oe, 0); chk("to_bus", d_out, 8'h00);
    cyc(); #1;
    chk("to_busy", busy, 0); chk("to_abort_end", aborted, 0);
    $display("txn write timeout");

    // FIFO overflow, packet-data ignore, soft reset
    dir = 1'b1; cyc();
    nxt = 1'b1; d_in = 8'hEE; cyc(); nxt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_in = 8'hA0 + 8'(i); cyc();
    end
    dir = 1'b0; d_in = 8'h00; #1;
    chk("ov_flag", rx_ovf, 1); chk("ov_head0", rx_byte, 8'hA0);
    rx_pop = 1'b1; cyc(); #1;
    chk("ov_head1", rx_byte, 8'hA1);
    cyc(); rx_pop = 1'b0; #1;
    chk("ov_head2", rx_byte, 8'hA2);
    ins_rst = 1'b1; cyc(); ins_rst = 1'b0; #1;
    chk("sr_valid", rx_valid, 0); chk("sr_ovf", rx_ovf, 0);
    $display("txn fifo overflow and soft reset");

    // Push with simultaneous pop at full
    dir = 1'b1; cyc();
    for (int i = 0; i < 4; i++) begin
      d_in = 8'hB0 + 8'(i); cyc();
    end
    d_in = 8'hB4; rx_pop = 1'b1; cyc(); rx_pop = 1'b0; dir = 1'b0; d_in = 8'h00; #1;
    chk("fp_ovf", rx_ovf, 0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("fp_head%0d", i), rx_byte, 8'hB0 + 8'(i));
      rx_pop = 1'b1; cyc(); rx_pop = 1'b0; #1;
    end
    chk("fp_empty", rx_valid, 0);
    rx_pop = 1'b1; cyc(); rx_pop = 1'b0; #1;
    chk("fp_pop_empty", rx_valid, 0);
    $display("txn fifo push/pop at full");

    // Read of extended address 0x85
`ifdef OUP_ULPI_EXTREG_EN
    start(8'h02, 8'h85, 8'h00); nxt = 1'b1; #1;
    chk("ex_tx", d_out, 8'hEF);
    cyc(); #1;
    chk("ex_addr", d_out, 8'h85); chk("ex_addr_oe", oe, 1);
    cyc(); nxt = 1'b0; #1;
    chk("ex_turn_oe", oe, 0);
    cyc(); dir = 1'b1;
    cyc(); d_in = 8'h5A;
    cyc(); dir = 1'b0; d_in = 8'h00; #1;
    chk("ex_done", done, 1); chk("ex_rdata", rdata, 8'h5A);
    cyc();
    $display("txn extended read addr=0x85 data=0x%02h", rdata);
`else
    start(8'h02, 8'h85, 8'h00); #1;
    chk("ex_abort", aborted, 1); chk("ex_oe0", oe, 0);
    cyc(); #1;
    chk("ex_oe1", oe, 0); chk("ex_busy", busy, 0);
    $display("txn extended read addr=0x85 rejected");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
